rf_write_queue: RTL and testbench

Buffered write-side front end for the 16 x 16-bit register file (RF). Accepts register-write requests from the datapath over a valid/ready handshake and queues them in order in a small FIFO. Retires one entry per cycle onto the RF write port, which uses active-low write enable, 4-bit write address and 16-bit write data. Also provides a newest-pending-write bypass lookup, so readers never see stale RF contents, and a drain handshake used before halting or displaying registers.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_write_queue_if.sv | 27 ++
 rtl/wq_fifo.sv | 70 +++++++
 rtl/rf_write_queue.sv | 116 +++++++++++
 tb/tb_rf_write_queue.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Constants and types shared by the register file, its decode logic and the
// write queue in front of it.
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int WQ_DEPTH = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/rf_write_queue_if.sv
// Valid/ready register-write request channel from the datapath to the
// write queue.
interface rf_write_queue_if #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/wq_fifo.sv
// In-order storage for pending RF writes; every slot is exposed so the top
// level can run the bypass search over the live entries.
module wq_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = WQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  wq_entry_t                push_entry_i,
  input  logic                     pop_i,
  output wq_entry_t                head_o,
  output logic [$clog2(DEPTH)-1:0] rptr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output wq_entry_t [DEPTH-1:0]    entries_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wq_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop_i) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Slots need no reset: the count alone decides which ones are live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= push_entry_i;
    end
  end

  assign head_o    = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign rptr_o    = rptr_q;
  assign count_o   = count_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/rf_write_queue.sv
// Buffered write front end for the 16x16 register file: queues datapath
// writes, retires one per cycle and offers a newest-first bypass lookup.
module rf_write_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = WQ_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rf_write_queue_if.slave        req,
  input  logic                   hold_i,
  input  logic                   drain_i,
  output logic                   done_o,
  output logic                   rf_webar_o,
  output logic [ADDR_W-1:0]      rf_wa_o,
  output logic [DATA_W-1:0]      rf_wd_o,
  input  logic [ADDR_W-1:0]      la_i,
  output logic                   lhit_o,
  output logic [DATA_W-1:0]      ldata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wq_state_t             state_q, state_d;
  logic                  reqReady;
  logic                  pushEn;
  logic                  popEn;
  logic                  drainEmpty;
  wq_entry_t             pushEntry;
  wq_entry_t             headEntry;
  wq_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      fifoCount;
  logic [PTR_W-1:0]      slotIdx;

  assign pushEntry.addr = req.req_addr;
  assign pushEntry.data = req.req_data;

  assign reqReady      = (fifoCount < FULL_CNT) && (state_q == RUN) && !rst_i;
  assign req.req_ready = reqReady;
  assign pushEn        = req.req_valid && reqReady;

  // The write enable sees only registered occupancy, HOLD and reset.
  assign popEn      = (fifoCount != '0) && !hold_i && !rst_i;
  assign rf_webar_o = !popEn;

  wq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (pushEn),
    .push_entry_i(pushEntry),
    .pop_i       (popEn),
    .head_o      (headEntry),
    .rptr_o      (rptr),
    .count_o     (fifoCount),
    .entries_o   (entries)
  );

  // Drain finishes at the edge that leaves the queue empty.
  assign drainEmpty = (fifoCount == {{(CNT_W-1){1'b0}}, popEn});

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drain_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drainEmpty) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign done_o  = (state_q == DONE) && !rst_i;
  assign count_o = rst_i ? '0 : fifoCount;
  assign rf_wa_o = rst_i ? '0 : headEntry.addr;
  assign rf_wd_o = rst_i ? '0 : headEntry.data;

  // Walk oldest to newest so a younger match overrides an older one.
  always_comb begin
    lhit_o  = 1'b0;
    ldata_o = '0;
    slotIdx = rptr;
    for (int k = 0; k < DEPTH; k++) begin
      slotIdx = rptr + PTR_W'(k);
      if ((CNT_W'(k) < fifoCount) && (entries[slotIdx].addr == la_i)) begin
        lhit_o  = 1'b1;
        ldata_o = entries[slotIdx].data;
      end
    end
    if (rst_i) begin
      lhit_o  = 1'b0;
      ldata_o = '0;
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Scoreboard bench for rf_write_queue: directed and random requests checked
// against a queue model of the pending writes.
module tb_rf_write_queue;
  import rf_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum {M_RUN, M_DRAIN, M_DONE} mode_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic              drain;
  logic              done;
  logic              rfWebar;
  logic [ADDR_W-1:0] rfWa;
  logic [DATA_W-1:0] rfWd;
  logic [ADDR_W-1:0] la;
  logic              lhit;
  logic [DATA_W-1:0] ldata;
  logic [2:0]        count;

  req_t  pendQ[$];
  req_t  sbQ[$];
  mode_t mMode = M_RUN;
  int    compared = 0;
  int    mismatched = 0;

  always #5 clk = ~clk;

  rf_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) reqIf ();

  rf_write_queue #(.DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req       (reqIf),
    .hold_i    (hold),
    .drain_i   (drain),
    .done_o    (done),
    .rf_webar_o(rfWebar),
    .rf_wa_o   (rfWa),
    .rf_wd_o   (rfWd),
    .la_i      (la),
    .lhit_o    (lhit),
    .ldata_o   (ldata),
    .count_o   (count)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Advance the reference model across one clock edge using the driven inputs.
  task automatic modelStep(output bit accepted);
    req_t r;
    accepted = 1'b0;
    if (rst) begin
      pendQ.delete();
      sbQ.delete();
      mMode = M_RUN;
      return;
    end
    r.addr   = reqIf.req_addr;
    r.data   = reqIf.req_data;
    accepted = reqIf.req_valid && (pendQ.size() < DEPTH) && (mMode == M_RUN);
    if (pendQ.size() > 0 && !hold) pendQ.delete(0);
    if (accepted) begin
      pendQ.push_back(r);
      sbQ.push_back(r);
    end
    case (mMode)
      M_RUN:   if (drain) mMode = M_DRAIN;
      M_DRAIN: if (pendQ.size() == 0) mMode = M_DONE;
      default: mMode = M_RUN;
    endcase
  endtask

  task automatic applyStimulus(input bit v, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input bit h, input bit dr,
                               input bit r, input logic [ADDR_W-1:0] l, output bit accepted);
    reqIf.req_valid = v;
    reqIf.req_addr  = a;
    reqIf.req_data  = d;
    hold  = h;
    drain = dr;
    rst   = r;
    la    = l;
    @(posedge clk);
    modelStep(accepted);
    #1;
  endtask

  task automatic pushReq(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit h, input logic [ADDR_W-1:0] l);
    bit acc;
    for (int t = 0; t < 16; t++) begin
      applyStimulus(1'b1, a, d, h, 1'b0, 1'b0, l, acc);
      if (acc) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL push_timeout at %0t: got no acceptance, want accepted within 16 cycles", $time);
  endtask

  task automatic idle(input int n, input bit h, input logic [ADDR_W-1:0] l);
    bit acc;
    for (int t = 0; t < n; t++) begin
      applyStimulus(1'b0, 4'(t), 16'(t), h, 1'b0, 1'b0, l, acc);
    end
  endtask

  // Every output is compared with the model once per cycle, mid-cycle.
  task automatic checkOutput();
    req_t              head;
    logic              expHit;
    logic [DATA_W-1:0] expData;
    int                size;
    size    = rst ? 0 : pendQ.size();
    head    = (size > 0) ? pendQ[0] : '0;
    expHit  = 1'b0;
    expData = '0;
    for (int i = size - 1; i >= 0; i--) begin
      if (!expHit && pendQ[i].addr == la) begin
        expHit  = 1'b1;
        expData = pendQ[i].data;
      end
    end
    cmp("count",     32'(count),           32'(size));
    cmp("rf_webar",  32'(rfWebar),         32'(!(size > 0 && !hold)));
    cmp("rf_wa",     32'(rfWa),            32'(head.addr));
    cmp("rf_wd",     32'(rfWd),            32'(head.data));
    cmp("req_ready", 32'(reqIf.req_ready), 32'(!rst && size < DEPTH && mMode == M_RUN));
    cmp("done",      32'(done),            32'(!rst && mMode == M_DONE));
    cmp("lhit",      32'(lhit),            32'(expHit));
    cmp("ldata",     32'(ldata),           32'(expData));
  endtask

  always @(negedge clk) begin
    checkOutput();
  end

  // Scoreboard: each RF write the DUT performs must be the oldest accepted request.
  always @(negedge clk) begin
    req_t e;
    if (rfWebar === 1'b0) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rf_write_extra at %0t: got write R%0d=0x%0h, want none pending",
                 $time, rfWa, rfWd);
      end else begin
        e = sbQ.pop_front();
        cmp("sb_addr", 32'(rfWa), 32'(e.addr));
        cmp("sb_data", 32'(rfWd), 32'(e.data));
      end
    end
  end

  initial begin
    bit acc;
    reqIf.req_valid = 1'b0;
    reqIf.req_addr  = '0;
    reqIf.req_data  = '0;
    rst   = 1'b1;
    hold  = 1'b0;
    drain = 1'b0;
    la    = '0;

    applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1, 4'd0, acc);
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1, 4'd1, acc);

    pushReq(4'd1, 16'd20, 1'b0, 4'd1);
    idle(3, 1'b0, 4'd1);

    pushReq(4'd8, 16'd31884, 1'b0, 4'd8);
    pushReq(4'd15, 16'd2222, 1'b0, 4'd15);
    pushReq(4'd14, 16'd10943, 1'b0, 4'd14);
    idle(3, 1'b0, 4'd14);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'(i + 2), 16'(16'h0100 + i), 1'b1, 1'b0, 1'b0, 4'(i + 2), acc);
    end
    for (int i = 0; i < 10; i++) begin
      pushReq(4'(i), 16'(16'h0200 + i), 1'b0, 4'(i));
    end
    idle(6, 1'b0, 4'd3);

    pushReq(4'd3, 16'h1111, 1'b1, 4'd3);
    pushReq(4'd3, 16'h2222, 1'b1, 4'd3);
    idle(1, 1'b1, 4'd3);
    idle(1, 1'b1, 4'd4);
    idle(4, 1'b0, 4'd3);

    pushReq(4'd5, 16'hAAAA, 1'b1, 4'd5);
    pushReq(4'd6, 16'hBBBB, 1'b1, 4'd6);
    pushReq(4'd7, 16'hCCCC, 1'b1, 4'd7);
    applyStimulus(1'b1, 4'd9, 16'h9999, 1'b0, 1'b1, 1'b0, 4'd6, acc);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'd9, 16'(16'h9000 + i), 1'b0, 1'b0, 1'b0, 4'd9, acc);
    end
    idle(2, 1'b0, 4'd9);

    for (int i = 0; i < 4; i++) begin
      pushReq(4'(i + 10), 16'(16'h0C00 + i), 1'b1, 4'(i + 10));
    end
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1, 4'd10, acc);
    idle(4, 1'b0, 4'd10);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    4'($urandom_range(0, 7)),
                    16'($urandom),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 99) == 0,
                    4'($urandom_range(0, 8)),
                    acc);
    end

    for (int t = 0; t < 20 && (pendQ.size() > 0 || mMode != M_RUN); t++) begin
      idle(1, 1'b0, 4'd0);
    end
    idle(1, 1'b0, 4'd0);
    cmp("sb_empty", 32'(sbQ.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
